// File: rtl/rename_map_pkg.sv
// Shared types for the rename stage: PR tag, arch-reg index and the renamed-instruction record.
// PR width derives from PHYS_REG_IDX_SZ (default 5 -> 6-bit tags).
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif

package rename_map_pkg;
  localparam int PR_W        = `PHYS_REG_IDX_SZ + 1;
  localparam int PHYS_REG_SZ = 1 << PR_W;
  localparam int AREG_W_DEF  = 5;

  typedef logic [PR_W-1:0]       pr_t;
  typedef logic [AREG_W_DEF-1:0] areg_t;

  typedef struct packed {
    pr_t  t;
    pr_t  told;
    pr_t  t1;
    pr_t  t2;
    logic t1_rdy;
    logic t2_rdy;
  } ren_t;

  function automatic logic tag_hit(input logic v, input pr_t a, input pr_t b);
    return v && (a == b);
  endfunction
endpackage

// File: rtl/rename_ready_table.sv
// Per-PR ready bits: cleared on allocation, set by CDB, all set on squash.
// Two combinational read ports see a same-cycle CDB broadcast; PR 0 reads as always ready.
module rename_ready_table
  import rename_map_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           alloc_en,
  input  pr_t            alloc_tag,
  input  logic           cdb_valid,
  input  pr_t            cdb_tag,
  input  logic           squash,
  input  pr_t [1:0]      rd_tag,
  output logic [1:0]     rd_rdy
);
  logic [PHYS_REG_SZ-1:0] rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy <= '1;
    end else if (squash) begin
      rdy <= '1;
    end else begin
      if (alloc_en)  rdy[alloc_tag] <= 1'b0;
      if (cdb_valid) rdy[cdb_tag]   <= 1'b1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rd
    assign rd_rdy[i] = rdy[rd_tag[i]] | tag_hit(cdb_valid, cdb_tag, rd_tag[i]) |
                       (rd_tag[i] == '0);
  end

  a_no_cdb_on_alloc: assert property (@(posedge clk) disable iff (!reset)
    !(alloc_en && cdb_valid && alloc_tag == cdb_tag));
endmodule

// File: rtl/rename_map.sv
// Register rename stage: speculative/arch map tables, free-list allocation and a one-deep output register.
// Define RENAME_PERF_EN to add the perf_renames / perf_fl_stalls counters.
module rename_map
  import rename_map_pkg::*;
#(
  parameter int ARCH_REGS = 32,
  parameter int AREG_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic              id_has_dest,
  input  logic [AREG_W-1:0] id_dest_areg,
  input  logic [AREG_W-1:0] id_src1_areg,
  input  logic [AREG_W-1:0] id_src2_areg,
  input  logic              fl_empty,
  input  pr_t               fl_pr,
  output logic              fl_dequeue_en,
  input  logic              cdb_valid,
  input  pr_t               cdb_tag,
  input  logic              rt_valid,
  input  logic [AREG_W-1:0] rt_areg,
  input  pr_t               rt_pr,
  input  logic              squash,
  output logic              out_valid,
  input  logic              out_ready,
  output pr_t               out_t,
  output pr_t               out_told,
  output pr_t               out_t1,
  output pr_t               out_t2,
  output logic              out_t1_rdy,
  output logic              out_t2_rdy
`ifdef RENAME_PERF_EN
  ,
  output logic [31:0]       perf_renames,
  output logic [31:0]       perf_fl_stalls
`endif
);
  logic [ARCH_REGS-1:0][PR_W-1:0] spec_map, arch_map, arch_nxt;
  pr_t [1:0]  src_tag;
  logic [1:0] src_rdy;
  pr_t        old_dest;
  ren_t       ren_d, out_q;
  logic       out_valid_q;
  logic       need_alloc, slot_free, fire;

  assign need_alloc    = id_has_dest && (id_dest_areg != '0);
  assign slot_free     = !out_valid_q || out_ready;
  assign id_ready      = reset && slot_free && !(need_alloc && fl_empty) && !squash;
  assign fire          = id_valid && id_ready;
  assign fl_dequeue_en = fire && need_alloc;

  // Lookups read the map as it stood before this cycle's allocation.
  assign src_tag[0] = spec_map[id_src1_areg];
  assign src_tag[1] = spec_map[id_src2_areg];
  assign old_dest   = spec_map[id_dest_areg];

  always_comb begin
    arch_nxt = arch_map;
    if (rt_valid && rt_areg != '0) arch_nxt[rt_areg] = rt_pr;
  end

  always_comb begin
    ren_d        = '0;
    ren_d.t      = need_alloc ? fl_pr : '0;
    ren_d.told   = need_alloc ? old_dest : '0;
    ren_d.t1     = src_tag[0];
    ren_d.t2     = src_tag[1];
    ren_d.t1_rdy = src_rdy[0];
    ren_d.t2_rdy = src_rdy[1];
  end

  rename_ready_table u_rdy (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (fl_dequeue_en),
    .alloc_tag (fl_pr),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .squash    (squash),
    .rd_tag    (src_tag),
    .rd_rdy    (src_rdy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      spec_map     <= '0;
      arch_map     <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_q.t1_rdy <= 1'b1;
      out_q.t2_rdy <= 1'b1;
    end else begin
      arch_map <= arch_nxt;
      if (squash) begin
        spec_map    <= arch_nxt;
        out_valid_q <= 1'b0;
      end else begin
        if (fl_dequeue_en) spec_map[id_dest_areg] <= fl_pr;
        if (fire) begin
          out_q       <= ren_d;
          out_valid_q <= 1'b1;
        end else begin
          if (slot_free) out_valid_q <= 1'b0;
          // A held instruction picks up wakeups so dispatch sees them.
          if (tag_hit(cdb_valid, cdb_tag, out_q.t1)) out_q.t1_rdy <= 1'b1;
          if (tag_hit(cdb_valid, cdb_tag, out_q.t2)) out_q.t2_rdy <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_t      = out_q.t;
  assign out_told   = out_q.told;
  assign out_t1     = out_q.t1;
  assign out_t2     = out_q.t2;
  assign out_t1_rdy = out_q.t1_rdy;
  assign out_t2_rdy = out_q.t2_rdy;

`ifdef RENAME_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_renames   <= '0;
      perf_fl_stalls <= '0;
    end else begin
      if (fire && perf_renames != '1) perf_renames <= perf_renames + 32'd1;
      if (id_valid && slot_free && need_alloc && fl_empty && perf_fl_stalls != '1)
        perf_fl_stalls <= perf_fl_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: doc/rename_map.md
# rename_map

Register-rename stage between decode and dispatch. Each cycle it accepts at most one decoded instruction and translates its source architectural registers to physical tags with ready bits. If the instruction writes a register, it allocates a destination physical register from the free list and records the previous mapping (Told) for the ROB. It keeps a speculative map, a retirement (architectural) map and per-PR ready bits; it restores the speculative map from the retirement map on a squash.

## Interface
Parameters:
- ARCH_REGS, 32, number of architectural registers; areg 0 is hardwired zero.
- AREG_W, 5, architectural index width.

Ports (PR = `PHYS_REG_IDX_SZ`+1 bits):
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; state resets on a clk edge while reset==0.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  rename accepts this cycle.
- id_has_dest, id_dest_areg, id_src1_areg, id_src2_areg  in  1/AREG_W/AREG_W/AREG_W  instruction fields.
- fl_empty  in  1  free list has no free PR.
- fl_pr  in  PR  PR offered by the free list, valid when !fl_empty.
- fl_dequeue_en  out  1  consume fl_pr this cycle.
- cdb_valid, cdb_tag  in  1/PR  completion broadcast; marks the tag ready.
- rt_valid, rt_areg, rt_pr  in  1/AREG_W/PR  retirement: arch map[rt_areg] <= rt_pr.
- squash  in  1  mispredict recovery.
- out_valid  out  1  renamed instruction held for dispatch.
- out_ready  in  1  dispatch takes the held instruction.
- out_t, out_told  out  PR  destination tag and previous mapping (both 0 if no destination).
- out_t1, out_t2  out  PR  source tags.
- out_t1_rdy, out_t2_rdy  out  1  source ready bits.

## Operation
- need_alloc = id_has_dest & (id_dest_areg != 0).
- slot_free = !out_valid | out_ready.
- id_ready = slot_free & !(need_alloc & fl_empty) & !squash.
- fire = id_valid & id_ready.
- fl_dequeue_en = fire & need_alloc.
- Lookup is combinational from the speculative map before this cycle's write.
  - A source that equals the destination reads the old mapping.
  - Source ready = ready[tag] | (cdb_valid & cdb_tag==tag).
  - PR 0 is always ready.
- On fire with need_alloc:
  - map[dest] <= fl_pr.
  - ready[fl_pr] <= 0.
  - out_told = old map[dest].
- When the output register is loaded:
  - It captures the lookup results and out_t (fl_pr, or 0 if no destination).
  - out_valid <= 1.
- If slot_free & !fire, out_valid <= 0.
- While held, out_t1_rdy/out_t2_rdy are set by a matching CDB broadcast.
- cdb_valid sets ready[cdb_tag] <= 1. A CDB write and an allocation of the same PR in one cycle are illegal; this is asserted.
- rt_valid with rt_areg != 0 updates the arch map. Retirement of areg 0 is ignored.
- squash:
  - Speculative map <= arch map, with this cycle's retire write applied.
  - All ready bits <= 1.
  - out_valid <= 0.
  - No fire and no dequeue that cycle.
- Priority: reset > squash > fire/CDB. Retire is applied in every non-reset cycle.
- Reset values:
  - Both maps are all 0 (every areg maps to PR 0).
  - All ready bits are 1.
  - out_valid, out_t, out_told, out_t1, out_t2 are 0; out_t1_rdy and out_t2_rdy are 1.
  - id_ready and fl_dequeue_en are 0 during reset.

## Timing
- Rename latency is 1 cycle: an instruction that fires in cycle n appears on out_* in cycle n+1.
- Back-to-back dependent instructions: a write at cycle n is visible to a lookup at n+1.
- fl_pr is consumed combinationally in the same cycle as fl_dequeue_en.
- Stall on fl_empty holds id_ready low with no state change.
- Output backpressure: out_* stay stable while out_valid & !out_ready, except the ready bits, which may rise.
- squash takes effect at the next edge. A reset asserted mid-stall discards the held instruction.

## Configuration
- RENAME_PERF_EN defined adds two 32-bit outputs, perf_renames and perf_fl_stalls.
  - perf_renames counts fire cycles.
  - perf_fl_stalls counts cycles with id_valid & slot_free & need_alloc & fl_empty.
  - Both counters clear on reset, saturate at all-ones, and are unaffected by squash.
- Absent: no counters and no ports.

## Structure
- Shared package:
  - PR tag typedef based on `PHYS_REG_IDX_SZ`.
  - AREG typedef.
  - Renamed-instruction struct {t, told, t1, t2, t1_rdy, t2_rdy}.
- Sub-module rename_ready_table holds the PHYS_REG_SZ ready bits.
  - Ports: clear on allocate, set on CDB, all-set on squash, 2 combinational read ports with CDB bypass.
- Map tables and the output register are in the top module.

## Test plan
- Reset, then rename add r3<-r1,r2 with fl_pr=5 → out_t=5, out_told=0, out_t1=out_t2=0, both rdy=1; fl_dequeue_en pulses 1 cycle.
- Next cycle r4<-r3,r3 with fl_pr=6 → out_t1=out_t2=5, rdy=0, out_told=0. Then cdb_tag=5 while held → rdy rise to 1.
- fl_empty=1 with id_has_dest=1 → id_ready=0, fl_dequeue_en=0, map unchanged. Dest r0 with fl_empty=1 → fires, out_t=0.
- out_ready=0 for 3 cycles → out_* stable, id_ready=0, no dequeue.
- Retire r3->5, rename r3->7, squash → next lookup of r3 returns 5 with rdy=1, out_valid=0. Squash with a same-cycle retire of r4->6 → r4 reads 6.
- With RENAME_PERF_EN: 4 renames and 2 free-list-stall cycles → perf_renames=4, perf_fl_stalls=2; both clear on reset.
